// File: rtl/univ_shift_reg.sv
// Universal shift register with true/complement outputs and a word counter.
//
// Supports hold, parallel load, logical shift left/right, arithmetic shift right,
// rotate left/right and clear. A shift counter (modulo WIDTH) flags every completed
// word with a one-cycle registered pulse, so the block can serve directly as a
// serializer or deserializer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         operation enable; low forces hold
//   mode       operation select (HOLD/LOAD/SHL/SHR/ASR/ROL/ROR/CLEAR)
//   D          parallel load data
//   si_l       serial input entering at bit 0 on shift-left
//   si_r       serial input entering at bit WIDTH-1 on shift-right
//   Q          registered contents
//   nQ         bitwise complement of Q
//   so_l       Q[WIDTH-1]
//   so_r       Q[0]
//   cnt        shift/rotate operations since last load/clear, modulo WIDTH
//   word_done  one-cycle pulse after the WIDTH-th shift
module univ_shift_reg #(
   parameter int unsigned       WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   parameter int unsigned       CNT_W     = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [2:0]        mode,
   input  logic [WIDTH-1:0]  D,
   input  logic              si_l,
   input  logic              si_r,
   output logic [WIDTH-1:0]  Q,
   output logic [WIDTH-1:0]  nQ,
   output logic              so_l,
   output logic              so_r,
   output logic [CNT_W-1:0]  cnt,
   output logic              word_done
);

   typedef enum logic [2:0] {
      ModeHold  = 3'b000,
      ModeLoad  = 3'b001,
      ModeShl   = 3'b010,
      ModeShr   = 3'b011,
      ModeAsr   = 3'b100,
      ModeRol   = 3'b101,
      ModeRor   = 3'b110,
      ModeClear = 3'b111
   } mode_e;

   // Counter wraps at WIDTH, not at 2^CNT_W, so non-power-of-two widths work.
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] r_q;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;

   logic [WIDTH-1:0] w_q_d;
   logic [CNT_W-1:0] w_cnt_d;
   logic             w_done_d;
   logic             w_shift;
   mode_e            w_mode;

   assign w_mode = mode_e'(mode);

   always_comb begin
      w_q_d    = r_q;
      w_cnt_d  = r_cnt;
      w_done_d = 1'b0;
      w_shift  = 1'b0;

      if (en) begin
         case (w_mode)
            ModeHold: ;
            ModeLoad: begin
               w_q_d   = D;
               w_cnt_d = '0;
            end
            ModeShl: begin
               w_q_d   = {r_q[WIDTH-2:0], si_l};
               w_shift = 1'b1;
            end
            ModeShr: begin
               w_q_d   = {si_r, r_q[WIDTH-1:1]};
               w_shift = 1'b1;
            end
            ModeAsr: begin
               w_q_d   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
               w_shift = 1'b1;
            end
            ModeRol: begin
               w_q_d   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
               w_shift = 1'b1;
            end
            ModeRor: begin
               w_q_d   = {r_q[0], r_q[WIDTH-1:1]};
               w_shift = 1'b1;
            end
            ModeClear: begin
               w_q_d   = RESET_VAL;
               w_cnt_d = '0;
            end
            default: ;
         endcase

         // All shift-class modes share one counter, whatever their mix.
         if (w_shift) begin
            if (r_cnt == CntLast) begin
               w_cnt_d  = '0;
               w_done_d = 1'b1;
            end else begin
               w_cnt_d = r_cnt + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q    <= RESET_VAL;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_q    <= w_q_d;
         r_cnt  <= w_cnt_d;
         r_done <= w_done_d;
      end
   end

   assign Q         = r_q;
   assign nQ        = ~r_q;
   assign so_l      = r_q[WIDTH-1];
   assign so_r      = r_q[0];
   assign cnt       = r_cnt;
   assign word_done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg: an 8-bit and a 6-bit instance driven in parallel,
// checked every cycle against an arithmetic model, plus directed literal checks.
module tb_univ_shift_reg;

   localparam logic [2:0] M_HOLD  = 3'd0;
   localparam logic [2:0] M_LOAD  = 3'd1;
   localparam logic [2:0] M_SHL   = 3'd2;
   localparam logic [2:0] M_SHR   = 3'd3;
   localparam logic [2:0] M_ASR   = 3'd4;
   localparam logic [2:0] M_ROL   = 3'd5;
   localparam logic [2:0] M_ROR   = 3'd6;
   localparam logic [2:0] M_CLEAR = 3'd7;

   localparam logic [5:0] RV6 = 6'h15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [2:0] mode;
   logic [7:0] d8;
   logic [5:0] d6;
   logic       si_l;
   logic       si_r;

   logic [7:0] q8, nq8;
   logic       sol8, sor8, wd8;
   logic [2:0] cnt8;
   logic [5:0] q6, nq6;
   logic       sol6, sor6, wd6;
   logic [2:0] cnt6;

   int checks   = 0;
   int failures = 0;
   bit chk_on   = 1'b0;

   always #5 clk = ~clk;

   assign d6 = d8[5:0];

   univ_shift_reg #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .D(d8), .si_l(si_l), .si_r(si_r),
      .Q(q8), .nQ(nq8), .so_l(sol8), .so_r(sor8), .cnt(cnt8), .word_done(wd8)
   );

   univ_shift_reg #(.WIDTH(6), .RESET_VAL(RV6)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .D(d6), .si_l(si_l), .si_r(si_r),
      .Q(q6), .nQ(nq6), .so_l(sol6), .so_r(sor6), .cnt(cnt6), .word_done(wd6)
   );

   task automatic chk(input string name, input longint unsigned act,
                      input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Next register value computed with plain arithmetic on a w-bit unsigned number.
   function automatic longint unsigned nxt(input int w, input longint unsigned q,
                                           input logic [2:0] m, input logic sl,
                                           input logic sr, input longint unsigned d,
                                           input longint unsigned rv);
      longint unsigned msk = (64'd1 << w) - 1;
      longint unsigned top = 64'd1 << (w - 1);
      case (m)
         3'd1:    return d & msk;
         3'd2:    return ((q * 2) + longint'(sl)) & msk;
         3'd3:    return (q / 2) + (sr ? top : 0);
         3'd4:    return (q / 2) + (q & top);
         3'd5:    return ((q * 2) & msk) + (q / top);
         3'd6:    return (q / 2) + ((q % 2) != 0 ? top : 0);
         3'd7:    return rv;
         default: return q;
      endcase
   endfunction

   longint unsigned m8_q, m6_q;
   int              m8_cnt, m6_cnt;
   bit              m8_wd, m6_wd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m8_q <= 0;   m8_cnt <= 0; m8_wd <= 0;
         m6_q <= RV6; m6_cnt <= 0; m6_wd <= 0;
      end else if (!en) begin
         m8_wd <= 0;
         m6_wd <= 0;
      end else begin
         m8_q <= nxt(8, m8_q, mode, si_l, si_r, d8, 0);
         m6_q <= nxt(6, m6_q, mode, si_l, si_r, d6, RV6);
         if (mode >= 3'd2 && mode <= 3'd6) begin
            m8_wd  <= (m8_cnt + 1 == 8);
            m8_cnt <= (m8_cnt + 1) % 8;
            m6_wd  <= (m6_cnt + 1 == 6);
            m6_cnt <= (m6_cnt + 1) % 6;
         end else begin
            m8_wd <= 0;
            m6_wd <= 0;
            if (mode != 3'd0) begin
               m8_cnt <= 0;
               m6_cnt <= 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("q8", q8, m8_q);
         chk("nq8", nq8, (~m8_q) & 64'hFF);
         chk("so_l8", sol8, (m8_q >> 7) & 1);
         chk("so_r8", sor8, m8_q & 1);
         chk("cnt8", cnt8, m8_cnt);
         chk("wd8", wd8, m8_wd);
         chk("q6", q6, m6_q);
         chk("nq6", nq6, (~m6_q) & 64'h3F);
         chk("so_l6", sol6, (m6_q >> 5) & 1);
         chk("so_r6", sor6, m6_q & 1);
         chk("cnt6", cnt6, m6_cnt);
         chk("wd6", wd6, m6_wd);
      end
   end

   // Inputs change 1 time unit after a rising edge and take effect on the next one.
   task automatic step(input logic e, input logic [2:0] m, input logic [7:0] d,
                       input logic sl, input logic sr);
      en = e; mode = m; d8 = d; si_l = sl; si_r = sr;
      @(posedge clk);
      #1;
   endtask

   logic       sl_stream [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic       sor_exp   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [7:0] shift_exp [5] = '{8'h02, 8'hC0, 8'hC0, 8'h03, 8'hC0};
   logic [2:0] shift_mode[5] = '{M_SHL, M_SHR, M_ASR, M_ROL, M_ROR};

   initial begin
      int found;
      int bit_i;
      int pulses;

      rst_n = 1'b0; en = 1'b0; mode = M_HOLD; d8 = '0; si_l = 1'b0; si_r = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_on = 1'b1;
      chk("reset_q", q8, 8'h00);
      chk("reset_nq", nq8, 8'hFF);
      chk("reset_q6", q6, 6'h15);

      // Load and enable gating
      step(1, M_LOAD, 8'hA5, 0, 0);
      chk("load_q", q8, 8'hA5);
      chk("load_nq", nq8, 8'h5A);
      chk("load_sol", sol8, 1);
      chk("load_sor", sor8, 1);
      repeat (3) step(0, M_SHL, 8'h00, 1, 1);
      chk("en_hold_q", q8, 8'hA5);
      chk("en_hold_cnt", cnt8, 0);

      // Single shifts from 0x81 (si_r=1 exercises SHR fill and must be ignored by ASR)
      for (int i = 0; i < 5; i++) begin
         step(1, M_LOAD, 8'h81, 0, 0);
         step(1, shift_mode[i], 8'h00, 0, 1);
         chk($sformatf("shift_mode%0d", shift_mode[i]), q8, shift_exp[i]);
      end

      // Serializer
      step(1, M_LOAD, 8'h96, 0, 0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ser_sor%0d", i), sor8, sor_exp[i]);
         step(1, M_SHR, 8'h00, 0, 0);
         chk($sformatf("ser_cnt%0d", i), cnt8, (i + 1) % 8);
         chk($sformatf("ser_wd%0d", i), wd8, (i == 7));
      end
      step(1, M_HOLD, 8'h00, 0, 0);
      chk("ser_wd_after", wd8, 0);

      // Deserializer with a 2-cycle enable stall mid-stream
      step(1, M_LOAD, 8'h00, 0, 0);
      found = -1;
      bit_i = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 5 || k == 6) begin
            step(0, M_SHL, 8'h00, 1, 0);
         end else if (bit_i < 8) begin
            step(1, M_SHL, 8'h00, sl_stream[bit_i], 0);
            bit_i++;
         end else begin
            step(1, M_HOLD, 8'h00, 0, 0);
         end
         if (wd8 && found < 0) begin
            found = k;
            chk("deser_q", q8, 8'hB2);
         end
      end
      chk("deser_wd_cycle", found, 10);

      // 5 shifts then CLEAR
      step(1, M_LOAD, 8'h5A, 0, 0);
      repeat (5) step(1, M_SHR, 8'h00, 1, 0);
      step(1, M_CLEAR, 8'h00, 0, 0);
      chk("clear_cnt", cnt8, 0);
      chk("clear_q", q8, 8'h00);
      chk("clear_q6", q6, 6'h15);

      // Async reset at cnt=7 swallows the pending word_done
      step(1, M_LOAD, 8'h3C, 0, 0);
      repeat (7) step(1, M_ROL, 8'h00, 0, 0);
      chk("pre_rst_cnt", cnt8, 7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_q", q8, 8'h00);
      chk("arst_nq", nq8, 8'hFF);
      chk("arst_cnt", cnt8, 0);
      chk("arst_wd", wd8, 0);
      @(posedge clk);
      #1;
      chk("arst_wd_edge", wd8, 0);
      rst_n = 1'b1;
      step(1, M_HOLD, 8'h00, 0, 0);
      chk("arst_wd_after", wd8, 0);

      // WIDTH=6: 12 shifts give exactly 2 pulses
      step(1, M_LOAD, 8'h2D, 0, 0);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         step(1, M_SHR, 8'h00, k[0], 0);
         if (wd6) pulses++;
      end
      step(1, M_HOLD, 8'h00, 0, 0);
      if (wd6) pulses++;
      chk("w6_pulses", pulses, 2);

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
